// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding one shared register; a grantee may lock
// its grant for up to HOLD_MAX consecutive writes.
module shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int HOLD_MAX = 4,
  localparam int OW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic [OW-1:0]      owner
);

  localparam int HW = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              qv_q, qv_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic [WIDTH-1:0]  slice [N];
  logic [OW-1:0]     nxt_ptr;
  logic [N-1:0]      others;
  logic [OW:0]       cand_idle, cand_rel;
  logic              keep;

  // {found, index} of the first set bit of r, scanning upward from start
  function automatic logic [OW:0] pick(
    input logic [N-1:0]  r,
    input logic [OW-1:0] start
  );
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N;
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  always_comb begin
    nxt_ptr   = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
    others    = req & ~(N'(1) << owner_q);
    cand_idle = pick(req, ptr_q);
    cand_rel  = pick(others, nxt_ptr);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    qv_d    = qv_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    keep    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cand_idle[OW]) begin
          state_d = BUSY;
          owner_d = cand_idle[OW-1:0];
          gnt_d   = N'(1) << cand_idle[OW-1:0];
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (req[owner_q]) begin
          q_d    = slice[owner_q];
          qv_d   = 1'b1;
          hold_d = hold_q + 1'b1;
        end
        keep = req[owner_q] & lock[owner_q]
             & (hold_q < HW'(HOLD_MAX - 1));
        // releasing owner is masked out, so it cannot win this edge
        if (!keep) begin
          ptr_d  = nxt_ptr;
          hold_d = '0;
          if (cand_rel[OW]) begin
            owner_d = cand_rel[OW-1:0];
            gnt_d   = N'(1) << cand_rel[OW-1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Vector-table bench for shared_reg_arbiter (N=4, WIDTH=8, HOLD_MAX=4)
// with an expected-value queue and per-cycle invariant monitor.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  shared_reg_arbiter #(.WIDTH(8), .N(4), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rb;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  own;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(
    input logic rb, input logic [3:0] r, input logic [3:0] l,
    input logic [31:0] w, input logic [3:0] g, input logic [7:0] qq,
    input logic v, input logic [1:0] o
  );
    vec_t t;
    t.rb = rb; t.req = r; t.lock = l; t.wd = w;
    t.gnt = g; t.q = qq; t.qv = v; t.own = o;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g,
                           input logic [7:0] qq, input logic v,
                           input logic [1:0] o);
    chk({tag, " gnt"}, 32'(gnt), 32'(g));
    chk({tag, " q"}, 32'(q), 32'(qq));
    chk({tag, " q_valid"}, 32'(q_valid), 32'(v));
    chk({tag, " owner"}, 32'(owner), 32'(o));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    lock = '0;
    wdata = '0;
    #1;
    chk_state("reset", 4'b0000, 8'h00, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int n);
    vec_t e;
    req = v.req;
    lock = v.lock;
    wdata = v.wd;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_state($sformatf("vec%0d", n), e.gnt, e.q, e.qv, e.own);
  endtask

  // invariants: one-hot-or-zero grant; q moves only on a granted write
  logic [7:0] prev_q;
  logic       wr_ok;
  logic       skip = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      skip = 1'b1;
    end else begin
      prev_q = q;
      wr_ok = |(gnt & req);
      skip = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL onehot: got gnt %b required one-hot or zero", gnt);
      end
      if (!skip) begin
        checks++;
        if (q !== prev_q && !wr_ok) begin
          errors++;
          $display("FAIL q_stable: got q %0h required %0h", q, prev_q);
        end
      end
    end
  end

  initial begin
    // single requester: grant, write, then alternate
    tbl.push_back(mk(1, 4'b0100, 0, 32'h00A5_0000, 4'b0100, 8'h00, 0, 2));
    tbl.push_back(mk(0, 4'b0100, 0, 32'h00A5_0000, 4'b0000, 8'hA5, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 0, 32'h00A5_0000, 4'b0100, 8'hA5, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 0, 32'h00A5_0000, 4'b0000, 8'hA5, 1, 2));
    // full round-robin, back-to-back
    tbl.push_back(mk(1, 4'b1111, 0, 32'h1312_1110, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h1312_1110, 4'b0010, 8'h10, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h1312_1110, 4'b0100, 8'h11, 1, 2));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h1312_1110, 4'b1000, 8'h12, 1, 3));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h1312_1110, 4'b0001, 8'h13, 1, 0));
    // lock cap: four writes by requester 0, then requester 1
    tbl.push_back(mk(1, 4'b0011, 4'b0001, 32'h3021, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h3022, 4'b0001, 8'h22, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h3023, 4'b0001, 8'h23, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h3024, 4'b0001, 8'h24, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h3025, 4'b0010, 8'h25, 1, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h3026, 4'b0001, 8'h30, 1, 0));
    // early drop by requester 1; next grant searches from ptr=2
    tbl.push_back(mk(1, 4'b0001, 0, 32'h0000_0055, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 32'h0000_EE55, 4'b0010, 8'h55, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0000_EE55, 4'b0000, 8'h55, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h0000_0000, 4'b0100, 8'h55, 1, 2));
    // locked tenure ahead of the async reset sequence
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 32'h77, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h77, 4'b0001, 8'h77, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rb) do_reset();
      apply(tbl[i], i);
    end

    // async reset between edges, mid-lock
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
    rst = 1'b0;
    #1;
    apply(mk(0, 4'b1000, 0, 32'h9900_0000, 4'b1000, 8'h00, 0, 3), 100);
    apply(mk(0, 4'b1000, 0, 32'h9900_0000, 4'b0000, 8'h99, 1, 3), 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the shared register and each write-data slice.
REQ-002 SHALL have parameter N, default 4: number of requesters; legal range 2..8.
REQ-003 SHALL have parameter HOLD_MAX, default 4: maximum consecutive write cycles in one locked tenure; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset; asynchronous and active-high.
REQ-006 SHALL have port req, input, N bits: req[i] = requester i wants to write.
REQ-007 SHALL have port lock, input, N bits: lock[i] = requester i asks to keep its grant for further writes.
REQ-008 SHALL have port wdata, input, N*WIDTH bits: slice [i*WIDTH +: WIDTH] is requester i's write data.
REQ-009 SHALL have port gnt, output, N bits: registered grant; one-hot or all-zero.
REQ-010 SHALL have port q, output, WIDTH bits: shared register contents.
REQ-011 SHALL have port q_valid, output, 1 bit: high once q has been written since reset.
REQ-012 SHALL have port owner, output, $clog2(N) bits: index of the current or most recent grantee.

Function
REQ-013 SHALL implement two states: IDLE (gnt all-zero) and BUSY (exactly one gnt bit high).
REQ-014 SHALL keep a round-robin pointer ptr; search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
REQ-015 IDLE: at an edge with any req bit high, SHALL grant the first requester in search order, set owner to it, clear hold_cnt, and go to BUSY; otherwise SHALL stay in IDLE.
REQ-016 BUSY, at an edge with req[owner]=1: SHALL load q with slice owner of wdata, set q_valid=1, and increment hold_cnt.
REQ-017 BUSY, at an edge with req[owner]=0: SHALL leave q unchanged and release the grant.
REQ-018 BUSY, keep the grant (stay BUSY, same owner) only when req[owner]=1, lock[owner]=1 and hold_cnt < HOLD_MAX-1 before the increment; otherwise SHALL release the grant.
REQ-019 On release, SHALL set ptr to (owner+1) mod N, searching from the new ptr value.
REQ-020 On release, if any req bit other than req[owner] is high, SHALL grant the first such requester at the same edge (back-to-back, no idle cycle) and clear hold_cnt; otherwise SHALL go to IDLE with gnt=0.
REQ-021 On release, the releasing owner SHALL NOT be re-granted at the same edge even if its req is still high.
REQ-022 SHALL give each unlocked grant exactly one write cycle; latency from req rising in IDLE to q update is 2 edges.
REQ-023 Writes SHALL occur only from the granted requester; wdata of ungranted requesters SHALL be ignored.
REQ-024 With HOLD_MAX=1, SHALL ignore lock (every tenure is one write).
REQ-025 SHALL hold q, q_valid and owner when no write or grant occurs.
REQ-026 gnt SHALL never have more than one bit set, in any state.

Reset
REQ-027 While rst=1, SHALL immediately force: state=IDLE, gnt=0, q=0, q_valid=0, owner=0, ptr=0, hold_cnt=0, independent of clk.
REQ-028 Reset asserted mid-tenure SHALL abort the tenure with no write at that edge; after rst deasserts, the first grant SHALL be evaluated at the next rising edge with ptr=0.

Verification
REQ-029 Scenario, single requester (N=4, WIDTH=8): req=0100, wdata[2]=0xA5, lock=0 -> gnt=0100 after edge 1; q=0xA5 and q_valid=1 after edge 2; then gnt alternates 0000/0100 while req is held.
REQ-030 Scenario, full round-robin: req=1111, lock=0, wdata[i]=0x10+i -> gnt sequence 0001, 0010, 0100, 1000, 0001 with no gap; q follows 0x10, 0x11, 0x12, 0x13.
REQ-031 Scenario, lock cap (HOLD_MAX=4): req=0011, lock=0001 -> requester 0 keeps gnt for exactly 4 writes, then gnt=0010 at the next edge.
REQ-032 Scenario, early drop: requester 1 granted and deasserts req before the write edge -> q unchanged, grant passes to the next requester or IDLE, ptr=2.
REQ-033 Scenario, async reset mid-lock: rst pulsed between edges during a locked tenure -> gnt=0, q=0, q_valid=0 before the next edge; with req=1000 afterwards, gnt=1000 after the first post-reset edge.
REQ-034 Scenario, invariants on every cycle of every test: gnt is one-hot or zero; q changes only at an edge where gnt[owner]=1 and req[owner]=1.
